// File: rtl/arb_pkg.sv
// Shared types and helpers for the one-hot round-robin arbiter.
// Holds the FSM state encoding and the index-width helper used by the top and the interface.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Width of a binary requester index; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb_one_hot_if.sv
// Request/grant bundle between requesters and the one-hot round-robin arbiter.
// master drives req/done; slave (the arbiter) returns the registered grant outputs.
interface rr_arb_one_hot_if
  import arb_pkg::*;
#(
  parameter int IN_NUM = 4
);

  logic [IN_NUM-1:0]         req;
  logic                      done;
  logic [IN_NUM-1:0]         gnt;
  logic                      gnt_vld;
  logic [idx_w(IN_NUM)-1:0]  gnt_idx;
  logic                      timeout;

  modport master (
    output req, done,
    input  gnt, gnt_vld, gnt_idx, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_vld, gnt_idx, timeout
  );

endinterface

// File: rtl/rr_pick.sv
// Purpose: combinational round-robin pick, first set mask bit at ptr, ptr+1, ... modulo IN_NUM.
// Latency: none (pure combinational). Backpressure: none; found=0 when mask is empty.
module rr_pick
  import arb_pkg::*;
#(
  parameter int IN_NUM = 4,
  parameter int IDX_W  = idx_w(IN_NUM)
) (
  input  logic [IN_NUM-1:0] mask,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  idx,
  output logic              found
);

  localparam int SW = IDX_W + 1;

  logic [IN_NUM-1:0] rot;
  logic [SW-1:0]     sum;

  // Bit i of rot is mask[(ptr + i) mod IN_NUM]; doubling the mask makes the wrap free.
  assign rot = IN_NUM'({mask, mask} >> ptr);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int i = 0; i < IN_NUM; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + SW'(i);
        if (sum >= SW'(IN_NUM)) begin
          sum = sum - SW'(IN_NUM);
        end
        idx = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_arb_one_hot.sv
// Purpose: round-robin arbiter with registered one-hot grant held until done/drop (optional hold timeout via RR_ARB_TIMEOUT_EN).
// Latency: 1 cycle req->gnt; back-to-back regrant on release with no idle bubble.
// Backpressure: owner holds grant until done, dropping its req, or (with RR_ARB_TIMEOUT_EN) MAX_HOLD-1 busy cycles.
module rr_arb_one_hot
  import arb_pkg::*;
#(
  parameter int IN_NUM   = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rr_arb_one_hot_if.slave  bus
);

  localparam int IDX_W = idx_w(IN_NUM);
  localparam logic [IN_NUM-1:0] ONE = IN_NUM'(1);

  if (IN_NUM < 2 || IN_NUM > 32) begin : g_bad_in_num
    $error("rr_arb_one_hot: IN_NUM must be 2..32");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_bad_max_hold
    $error("rr_arb_one_hot: MAX_HOLD must be 2..65535");
  end

  state_t            state_q, state_d;
  logic [IN_NUM-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              vld_q, vld_d;

  logic [IN_NUM-1:0] mask;
  logic [IDX_W-1:0]  win_idx;
  logic              win_found;
  logic              owner_req;
  logic              hold_hit;
  logic              release_ev;
  logic              arbitrate;

  assign owner_req  = bus.req[idx_q];
  assign release_ev = (state_q == BUSY) && (bus.done || !owner_req || hold_hit);
  assign arbitrate  = (state_q == IDLE) || release_ev;
  // The releasing owner must not win its own re-arbitration.
  assign mask       = (state_q == BUSY) ? (bus.req & ~gnt_q) : bus.req;

  rr_pick #(
    .IN_NUM (IN_NUM),
    .IDX_W  (IDX_W)
  ) u_pick (
    .mask   (mask),
    .ptr    (ptr_q),
    .idx    (win_idx),
    .found  (win_found)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    ptr_d   = ptr_q;
    if (arbitrate) begin
      if (win_found) begin
        state_d = BUSY;
        gnt_d   = ONE << win_idx;
        idx_d   = win_idx;
        vld_d   = 1'b1;
        ptr_d   = (win_idx == IDX_W'(IN_NUM - 1)) ? '0 : win_idx + 1'b1;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        vld_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  logic [15:0] hold_q, hold_d;
  logic        timeout_q, timeout_d;

  assign hold_hit = (state_q == BUSY) && (hold_q == 16'(MAX_HOLD - 1));

  always_comb begin
    timeout_d = hold_hit && !bus.done && owner_req;
    hold_d    = '0;
    if (state_q == BUSY && !release_ev) begin
      hold_d = hold_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign hold_hit    = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.gnt     = gnt_q;
  assign bus.gnt_vld = vld_q;
  assign bus.gnt_idx = idx_q;

endmodule

// File: tb/tb_rr_arb_one_hot.sv
// Scoreboard bench for rr_arb_one_hot (IN_NUM=4, MAX_HOLD=4); honours RR_ARB_TIMEOUT_EN.
module tb_rr_arb_one_hot;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] gnt;
    logic       vld;
    logic [1:0] idx;
    logic       tmo;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t q[$];
  int   checks;
  int   errors;

  // Reference state: owner index (-1 when nobody holds), rotating start and hold age.
  int m_owner;
  int m_ptr;
  int m_hold;

  rr_arb_one_hot_if #(.IN_NUM(N)) bus ();

  rr_arb_one_hot #(
    .IN_NUM   (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] m, input int start);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  // Drive inputs at a falling edge, predict the state after the next rising edge, queue it.
  task automatic step(input logic [3:0] r, input logic d);
    int   w;
    bit   hit;
    bit   tmo_e;
    exp_t e;
    bus.req  = r;
    bus.done = d;
    tmo_e    = 1'b0;
    if (m_owner < 0) begin
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_ptr = (w + 1) % N; m_hold = 0;
      end
    end else begin
      hit = TMO && (m_hold == MAX_HOLD - 1);
      if (d || !r[m_owner] || hit) begin
        tmo_e = hit && !d && r[m_owner];
        w = pick(r & ~(4'b0001 << m_owner), m_ptr);
        if (w >= 0) begin
          m_owner = w; m_ptr = (w + 1) % N; m_hold = 0;
        end else begin
          m_owner = -1; m_hold = 0;
        end
      end else begin
        m_hold = m_hold + 1;
      end
    end
    e.gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e.vld = (m_owner >= 0);
    e.idx = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    e.tmo = tmo_e;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (bus.gnt !== 4'b0 || bus.gnt_vld !== 1'b0 || bus.gnt_idx !== 2'd0 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL %s: gnt=%b vld=%b idx=%0d tmo=%b, required all zero",
               name, bus.gnt, bus.gnt_vld, bus.gnt_idx, bus.timeout);
    end
  endtask

  // Let the monitor consume the last prediction, then reset asynchronously away from any edge.
  task automatic do_reset(input string name);
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: %0d predictions pending, required 0", name, q.size());
      q.delete();
    end
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
    #1;
    check_zero(name);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
  endtask

  initial begin : monitor
    exp_t e;
    exp_t got;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && q.size() > 0) begin
        e   = q.pop_front();
        got = {bus.gnt, bus.gnt_vld, bus.gnt_idx, bus.timeout};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL sb: got gnt=%b vld=%b idx=%0d tmo=%b, required gnt=%b vld=%b idx=%0d tmo=%b",
                   got.gnt, got.vld, got.idx, got.tmo, e.gnt, e.vld, e.idx, e.tmo);
        end
      end
    end
  end

  initial begin : driver
    logic [3:0] r;
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
    m_owner  = -1;
    m_ptr    = 0;
    m_hold   = 0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;

    // First grant on the first edge after reset, from index 0 onward.
    step(4'b0110, 1'b0);
    step(4'b0110, 1'b0);

    // Full rotation with done each grant and no idle cycle.
    do_reset("rotate");
    step(4'b1111, 1'b0);
    repeat (4) step(4'b1111, 1'b1);
    step(4'b0000, 1'b1);

    // Newcomer waits for done, then wins directly.
    do_reset("hold");
    step(4'b0100, 1'b0);
    step(4'b1100, 1'b0);
    step(4'b1100, 1'b0);
    step(4'b1100, 1'b1);
    step(4'b1000, 1'b0);

    // Sole owner releases -> idle; done while idle is ignored.
    do_reset("to_idle");
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);

`ifdef RR_ARB_TIMEOUT_EN
    do_reset("timeout");
    step(4'b0010, 1'b0);
    repeat (4) step(4'b0011, 1'b0);
    repeat (5) step(4'b0011, 1'b0);
`endif

    // Reset while BUSY drops the grant; arbitration restarts at index 0.
    do_reset("busy_rst_pre");
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    do_reset("busy_rst");
    step(4'b1001, 1'b0);
    step(4'b1001, 1'b1);

    r = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      step(r, ($urandom_range(0, 3) == 0));
    end

    do_reset("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arb_one_hot.md
RR_ARB_ONE_HOT -- requirements
Module: rr_arb_one_hot

Interface
REQ-001 SHALL have parameter IN_NUM, default 4, number of requesters (2..32).
REQ-002 SHALL have parameter MAX_HOLD, default 16, timeout limit in cycles (2..65535); used only with RR_ARB_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  IN_NUM  per-requester request level.
REQ-006 SHALL have port done  input  1  current owner releases grant (sampled only in BUSY).
REQ-007 SHALL have port gnt  output  IN_NUM  registered one-hot grant; drives the one-hot mux select directly.
REQ-008 SHALL have port gnt_vld  output  1  registered, high when gnt is nonzero.
REQ-009 SHALL have port gnt_idx  output  $clog2(IN_NUM)  registered binary index of gnt bit; 0 when gnt_vld low.
REQ-010 SHALL have port timeout  output  1  registered one-cycle pulse on forced release.

Function
REQ-011 SHALL implement FSM with states IDLE and BUSY.
REQ-012 SHALL keep rotating pointer ptr (width of gnt_idx), reset 0.
REQ-013 Winner SHALL be the first set req bit at index ptr, ptr+1, ... wrapping modulo IN_NUM.
REQ-014 IDLE with req nonzero: next edge gnt = one-hot(winner), gnt_idx = winner, gnt_vld = 1, ptr = (winner+1) mod IN_NUM, go BUSY (latency 1 cycle req->gnt).
REQ-015 IDLE with req zero: outputs stay 0, ptr unchanged.
REQ-016 BUSY: gnt, gnt_idx, gnt_vld SHALL hold constant regardless of other req changes until a release event.
REQ-017 Release event = done high, or req[gnt_idx] low (owner dropped request), or timeout (REQ-027).
REQ-018 On release with any other req bit set, next edge SHALL grant the new winner directly (no bubble), update ptr, stay BUSY; the released owner's req bit SHALL be excluded from that arbitration.
REQ-019 On release with no other req set, next edge SHALL clear gnt, gnt_idx, gnt_vld and go IDLE.
REQ-020 done in IDLE SHALL be ignored.
REQ-021 gnt SHALL never have more than one bit set; gnt_vld SHALL equal |gnt every cycle.
REQ-022 IN_NUM not a power of two: wrap SHALL be modulo IN_NUM, ptr never exceeds IN_NUM-1.

Reset
REQ-023 rst_n low SHALL asynchronously force gnt=0, gnt_idx=0, gnt_vld=0, timeout=0, ptr=0, state IDLE, hold counter 0.
REQ-024 Reset asserted mid-BUSY SHALL drop grant immediately; after deassertion arbitration restarts from index 0.
REQ-025 First grant SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro RR_ARB_TIMEOUT_EN SHALL compile in the hold-timeout feature.
REQ-027 With it: counter of BUSY cycles with the same owner, cleared on each new grant; if it reaches MAX_HOLD-1 without release, that cycle SHALL be a release event and timeout SHALL pulse high for one cycle on the next edge.
REQ-028 Without it: no counter logic; timeout SHALL be tied 0; owner holds indefinitely.

Structure
REQ-029 Package arb_pkg SHALL hold the state typedef (IDLE, BUSY) and a function returning index width for IN_NUM.
REQ-030 Combinational sub-module rr_pick SHALL compute winner index and found flag from req mask and ptr; instantiated once.

Verification (IN_NUM=4, MAX_HOLD=4)
REQ-031 Reset, then req=4'b0110 -> after 1 edge gnt=4'b0010, gnt_idx=1, ptr=2.
REQ-032 req=4'b1111 held, done pulsed each grant -> gnt sequence 0001,0010,0100,1000,0001 with no idle cycle.
REQ-033 Owner 2 granted, req[3] rises mid-BUSY -> gnt stays 0100 until done; then 1000 next edge.
REQ-034 Owner 0 granted, req=4'b0001 only, done=1 -> next edge gnt=0, gnt_vld=0, state IDLE.
REQ-035 RR_ARB_TIMEOUT_EN: owner 1 granted, done never asserted, req=4'b0011 -> timeout pulses 4 edges after grant, gnt=0001 on the same edge.
REQ-036 rst_n pulsed low while gnt=1000 -> gnt=0 immediately; after release, req=4'b1001 -> gnt=0001.
